// File: rtl/axis_fft_sink.sv
// AXI-Stream sink that captures one FFT frame into a bin-indexed buffer.
// Beats land at buf[tuser]; frame length is checked against POINTS.
//
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   s_axis_tdata      : {imag, real} beat, DATA_W bits
//   s_axis_tvalid     : upstream beat valid
//   s_axis_tready     : high while receiving or discarding a frame
//   s_axis_tlast      : last beat of the frame
//   s_axis_tuser      : bin index in [IDX_W-1:0], upper bits ignored
//   frame_req         : one-cycle arm request for the next frame
//   rd_addr, rd_data  : buffer read port, one cycle latency
//   frame_done        : one-cycle pulse on the first cycle in HOLD
//   busy              : high while a frame is in progress
//   err_len           : sticky length error for the current/last frame
//   beat_cnt          : beats accepted in the current/last frame

module axis_fft_sink #(
    parameter int POINTS = 1024,
    parameter int DATA_W = 48,
    parameter int IDX_W  = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    input  logic              s_axis_tlast,
    input  logic [23:0]       s_axis_tuser,
    input  logic              frame_req,
    input  logic [IDX_W-1:0]  rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              frame_done,
    output logic              busy,
    output logic              err_len,
    output logic [IDX_W:0]    beat_cnt
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RECV    = 2'd1,
        DISCARD = 2'd2,
        HOLD    = 2'd3
    } state_t;

    localparam logic [IDX_W:0] CNT_ONE  = (IDX_W+1)'(1);
    localparam logic [IDX_W:0] CNT_LAST = (IDX_W+1)'(POINTS - 1);
    localparam logic [IDX_W:0] CNT_FULL = (IDX_W+1)'(POINTS);

    state_t            state_q;
    state_t            state_d;
    logic [IDX_W:0]    beat_cnt_q;
    logic [IDX_W:0]    beat_cnt_d;
    logic              err_len_q;
    logic              err_len_d;
    logic              frame_done_q;
    logic              frame_done_d;
    logic [DATA_W-1:0] rd_data_q;

    // Simple dual-port storage: one write port, one registered read port.
    logic [DATA_W-1:0] fft_mem [POINTS];

    logic              accept;
    logic              wr_en;
    logic [IDX_W-1:0]  wr_addr;
    logic              unused_tuser;

    // Handshake is a pure decode of the state register, so tready
    // drops on the cycle right after the final beat moves us to HOLD.
    assign s_axis_tready = (state_q == RECV) || (state_q == DISCARD);
    assign busy          = s_axis_tready;
    assign accept        = s_axis_tvalid && s_axis_tready;
    assign wr_en         = accept && (state_q == RECV);
    assign wr_addr       = s_axis_tuser[IDX_W-1:0];
    assign unused_tuser  = ^s_axis_tuser[23:IDX_W];

    assign frame_done = frame_done_q;
    assign err_len    = err_len_q;
    assign beat_cnt   = beat_cnt_q;
    assign rd_data    = rd_data_q;

    always_comb begin
        state_d      = state_q;
        beat_cnt_d   = beat_cnt_q;
        err_len_d    = err_len_q;
        frame_done_d = 1'b0;
        unique case (state_q)
            IDLE, HOLD: begin
                if (frame_req) begin
                    state_d    = RECV;
                    beat_cnt_d = '0;
                    err_len_d  = 1'b0;
                end
            end
            RECV: begin
                if (accept) begin
                    beat_cnt_d = beat_cnt_q + CNT_ONE;
                    if (s_axis_tlast) begin
                        state_d      = HOLD;
                        frame_done_d = 1'b1;
                        // Short frame: tlast before the last bin.
                        if (beat_cnt_q != CNT_LAST) begin
                            err_len_d = 1'b1;
                        end
                    end else if (beat_cnt_q == CNT_LAST) begin
                        // Long frame: buffer is full, drain the rest.
                        state_d   = DISCARD;
                        err_len_d = 1'b1;
                    end
                end
            end
            DISCARD: begin
                if (accept) begin
                    beat_cnt_d = CNT_FULL;
                    if (s_axis_tlast) begin
                        state_d      = HOLD;
                        frame_done_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            beat_cnt_q   <= '0;
            err_len_q    <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            beat_cnt_q   <= beat_cnt_d;
            err_len_q    <= err_len_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Storage is never reset; contents persist across frames.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            fft_mem[wr_addr] <= s_axis_tdata;
        end
    end

    // Read-before-write: a same-cycle write to rd_addr returns old data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= fft_mem[rd_addr];
        end
    end

endmodule

// File: tb/tb_axis_fft_sink.sv
// Scoreboard bench for axis_fft_sink: stimulus pushes expected frame
// results and read data; a negedge monitor pops and compares.

module tb_axis_fft_sink;

    localparam int N = 1024;

    typedef struct packed {
        logic        err;
        logic [10:0] cnt;
    } exp_frame_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [47:0] s_axis_tdata = '0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic        s_axis_tlast = 1'b0;
    logic [23:0] s_axis_tuser = '0;
    logic        frame_req = 1'b0;
    logic [9:0]  rd_addr = '0;
    logic [47:0] rd_data;
    logic        frame_done;
    logic        busy;
    logic        err_len;
    logic [10:0] beat_cnt;

    int checks = 0;
    int failures = 0;

    exp_frame_t  exp_frames[$];
    logic [47:0] rd_exp[$];
    logic [47:0] model [N];
    logic        rd_req = 1'b0;
    logic        rd_pend = 1'b0;
    exp_frame_t  mf;
    logic [47:0] md;

    axis_fft_sink dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .s_axis_tlast (s_axis_tlast),
        .s_axis_tuser (s_axis_tuser),
        .frame_req    (frame_req),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .frame_done   (frame_done),
        .busy         (busy),
        .err_len      (err_len),
        .beat_cnt     (beat_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) rd_pend <= rd_req;

    always @(negedge clk) begin
        if (rst_n && frame_done) begin
            if (exp_frames.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_frame_done actual=1 required=0");
            end else begin
                mf = exp_frames.pop_front();
                chk("frame_err_len", 64'(err_len), 64'(mf.err));
                chk("frame_beat_cnt", 64'(beat_cnt), 64'(mf.cnt));
                chk("frame_tready_low", 64'(s_axis_tready), 64'd0);
            end
        end
        if (rd_pend) begin
            if (rd_exp.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_read actual=%0h required=none",
                         rd_data);
            end else begin
                md = rd_exp.pop_front();
                chk("rd_data", 64'(rd_data), 64'(md));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_req();
        frame_req = 1'b1;
        tick();
        frame_req = 1'b0;
    endtask

    task automatic send_beat(input logic [47:0] d, input int u,
                             input logic l);
        int n = 0;
        s_axis_tdata  = d;
        s_axis_tuser  = 24'(u);
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        forever begin
            @(negedge clk);
            if (s_axis_tready) break;
            n++;
            if (n > 50) begin
                checks++;
                failures++;
                $display("FAIL beat_timeout actual=tready0 required=tready1");
                break;
            end
        end
        tick();
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic gap_cycle();
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = 48'hDEAD_BEEF_0BAD;
        s_axis_tuser  = 24'($urandom_range(0, N - 1));
        s_axis_tlast  = 1'b0;
        tick();
    endtask

    task automatic rd(input int a);
        rd_addr = 10'(a);
        rd_req  = 1'b1;
        rd_exp.push_back(model[a]);
        tick();
        rd_req = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 20; k++) begin
            if (exp_frames.size() == 0 && rd_exp.size() == 0 && !rd_pend)
                break;
            tick();
        end
        chk("drain_frames", 64'(exp_frames.size()), 64'd0);
        chk("drain_reads", 64'(rd_exp.size()), 64'd0);
    endtask

    initial begin
        logic [47:0] d;
        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tready", 64'(s_axis_tready), 64'd0);
        chk("rst_frame_done", 64'(frame_done), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_err_len", 64'(err_len), 64'd0);
        chk("rst_beat_cnt", 64'(beat_cnt), 64'd0);
        chk("rst_rd_data", 64'(rd_data), 64'd0);
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        chk("idle_no_req_tready", 64'(s_axis_tready), 64'd0);
        tick();

        // nominal frame
        pulse_req();
        for (int i = 0; i < N; i++) begin
            d = 48'(i * 3);
            model[i] = d;
            if (i == N - 1) exp_frames.push_back('{1'b0, 11'd1024});
            send_beat(d, i, i == N - 1);
        end
        drain();
        rd(5);
        rd(0);
        rd(1023);
        drain();
        chk("nom_busy", 64'(busy), 64'd0);
        chk("nom_cnt_hold", 64'(beat_cnt), 64'd1024);

        // backpressure, reversed index order
        pulse_req();
        for (int i = 0; i < N; i++) begin
            while ($urandom_range(0, 99) < 30) gap_cycle();
            d = {24'(i), 24'(i ^ 32'h5a5)};
            model[N - 1 - i] = d;
            if (i == N - 1) exp_frames.push_back('{1'b0, 11'd1024});
            send_beat(d, N - 1 - i, i == N - 1);
        end
        drain();
        for (int a = 0; a < N; a++) rd(a);
        drain();

        // short frame
        pulse_req();
        for (int i = 0; i < 100; i++) begin
            d = 48'(i + 7000);
            model[i] = d;
            if (i == 99) exp_frames.push_back('{1'b1, 11'd100});
            send_beat(d, i, i == 99);
        end
        drain();
        chk("short_tready", 64'(s_axis_tready), 64'd0);
        chk("short_err_sticky", 64'(err_len), 64'd1);
        rd(99);
        rd(100);
        drain();

        // long frame: 1030 beats, only the first 1024 stored
        pulse_req();
        for (int i = 0; i < 1030; i++) begin
            d = 48'(i + 32'h100000);
            if (i < N) model[i % N] = d;
            if (i == 1029) exp_frames.push_back('{1'b1, 11'd1024});
            send_beat(d, i % N, i == 1029);
            if (i == 1026) begin
                @(negedge clk);
                chk("discard_busy", 64'(busy), 64'd1);
                chk("discard_cnt_sat", 64'(beat_cnt), 64'd1024);
                chk("discard_err", 64'(err_len), 64'd1);
            end
        end
        drain();
        for (int a = 0; a < 8; a++) rd(a);
        rd(1023);
        drain();

        // reset mid-frame
        pulse_req();
        for (int i = 0; i < 500; i++) send_beat(48'(i + 9), i, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_tready", 64'(s_axis_tready), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_cnt", 64'(beat_cnt), 64'd0);
        chk("midrst_err", 64'(err_len), 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        chk("midrst_idle", 64'(s_axis_tready), 64'd0);
        tick();
        pulse_req();
        for (int i = 0; i < N; i++) begin
            d = 48'(i * 5);
            model[i] = d;
            if (i == N - 1) exp_frames.push_back('{1'b0, 11'd1024});
            send_beat(d, i, i == N - 1);
        end
        drain();
        rd(0);
        rd(499);
        rd(500);
        drain();

        // frame_req while busy, duplicate index, read-during-write
        pulse_req();
        for (int i = 0; i < N; i++) begin
            int u;
            u = (i == 21) ? 20 : i;
            d = 48'(i + 42);
            if (i == 10) frame_req = 1'b1;
            if (i == 30) begin
                rd_addr = 10'(30);
                rd_req  = 1'b1;
                rd_exp.push_back(model[30]);
            end
            if (i != 21 || 1) begin
                if (i != 21) model[u] = d;
            end
            if (i == 21) model[20] = d;
            if (i == N - 1) exp_frames.push_back('{1'b0, 11'd1024});
            send_beat(d, u, i == N - 1);
            frame_req = 1'b0;
            rd_req    = 1'b0;
        end
        drain();
        rd(20);
        rd(21);
        rd(22);
        rd(30);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/axis_fft_sink.md
AXIS_FFT_SINK -- requirements
Module: axis_fft_sink

Interface
REQ-001 SHALL have parameter POINTS, default 1024: number of FFT bins per frame.
REQ-002 SHALL have parameter DATA_W, default 48: beat width, {imag[47:24], real[23:0]}.
REQ-003 SHALL have parameter IDX_W, default 10: bin index width, equal to clog2(POINTS).
REQ-004 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-006 SHALL have port s_axis_tdata, input, DATA_W: FFT output beat.
REQ-007 SHALL have port s_axis_tvalid, input, 1: upstream beat valid.
REQ-008 SHALL have port s_axis_tready, output, 1: sink ready.
REQ-009 SHALL have port s_axis_tlast, input, 1: last beat of frame.
REQ-010 SHALL have port s_axis_tuser, input, 24: bits [IDX_W-1:0] carry the bin index; other bits are ignored.
REQ-011 SHALL have port frame_req, input, 1: single-cycle arm request for the next frame.
REQ-012 SHALL have port rd_addr, input, IDX_W: buffer read address.
REQ-013 SHALL have port rd_data, output, DATA_W: buffer read data.
REQ-014 SHALL have port frame_done, output, 1: one-cycle pulse when a frame ends.
REQ-015 SHALL have port busy, output, 1: high in RECV or DISCARD.
REQ-016 SHALL have port err_len, output, 1: sticky frame-length error flag.
REQ-017 SHALL have port beat_cnt, output, IDX_W+1: number of beats accepted in the current or last frame.

Function
REQ-018 SHALL implement the states IDLE, RECV, DISCARD and HOLD.
REQ-019 SHALL drive s_axis_tready = 1 only in RECV or DISCARD, decoded directly from the state register.
REQ-020 SHALL accept a beat only on a cycle where s_axis_tvalid and s_axis_tready are both 1.
REQ-021 SHALL, in IDLE or HOLD with frame_req=1, move to RECV on the next cycle, clear err_len and clear beat_cnt to 0.
REQ-022 SHALL ignore frame_req in RECV or DISCARD.
REQ-023 SHALL, in RECV, write each accepted beat to buf[s_axis_tuser[IDX_W-1:0]] and increment beat_cnt.
REQ-024 SHALL, on an accepted beat in RECV with tlast=1 and beat_cnt==POINTS-1, go to HOLD with err_len unchanged.
REQ-025 SHALL, on an accepted beat in RECV with tlast=1 and beat_cnt<POINTS-1 (short frame), write the beat, set err_len and go to HOLD.
REQ-026 SHALL, on an accepted beat in RECV with tlast=0 and beat_cnt==POINTS-1 (long frame), write the beat, set err_len and go to DISCARD.
REQ-027 SHALL, in DISCARD, accept beats with no writes, saturate beat_cnt at POINTS, and go to HOLD on the accepted beat with tlast=1.
REQ-028 SHALL pulse frame_done for exactly one cycle, the cycle after the transition into HOLD.
REQ-029 SHALL drop s_axis_tready to 0 on the cycle after the final accepted beat.
REQ-030 SHALL keep buffer contents in HOLD and IDLE until overwritten by a later frame.
REQ-031 SHALL store duplicate indices last-write-wins, with no error.
REQ-032 SHALL register rd_data from buf[rd_addr] with 1-cycle latency, in every state.
REQ-033 SHALL, for a read during RECV of the address written in the same cycle, return the old data.
REQ-034 SHALL make the buffer inferable as a simple dual-port RAM: 1 write port, 1 read port, POINTS x DATA_W.
REQ-035 SHALL keep beat_cnt stable in HOLD.

Reset
REQ-036 SHALL, while rst_n=0, force state=IDLE, s_axis_tready=0, frame_done=0, busy=0, err_len=0, beat_cnt=0 and rd_data=0.
REQ-037 SHALL, on reset asserted mid-frame, abort immediately; the buffer is not cleared, and the partial frame contents are unspecified.
REQ-038 SHALL, after reset release, stay in IDLE until frame_req.

Verification
REQ-039 SHALL verify the nominal frame: frame_req, then 1024 beats with tuser=i and tdata=i*3, and tlast on beat 1023 -> one frame_done pulse, err_len=0, beat_cnt=1024, and rd_addr=5 returns 15 one cycle later.
REQ-040 SHALL verify backpressure: random s_axis_tvalid gaps at 30% -> every beat is stored, and no beat is written while tvalid=0.
REQ-041 SHALL verify the short frame: tlast on beat 99 -> err_len=1, beat_cnt=100, frame_done pulses, then tready=0.
REQ-042 SHALL verify the long frame: 1030 beats with tlast on the last -> err_len=1, beat_cnt=1024, buf[0..1023] equal the first 1024 beats, and frame_done pulses after beat 1030.
REQ-043 SHALL verify reset mid-frame: rst_n low at beat 500 -> tready=0 and state IDLE; a new frame_req then gives a clean frame with err_len=0.
REQ-044 SHALL verify that frame_req is ignored while busy: frame_req pulsed at beat 10 -> no restart, and beat_cnt=1024 at the end.
